// File: rtl/pbgen_pkg.sv
// Shared definitions for the frame parity generator: FSM encoding,
// parity-mode constants and the mode-adjusted reduction parity helper.
package pbgen_pkg;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves their parity unchanged.
  localparam int unsigned MAX_DATA_W = 64;

  // Parity sense: even parity makes the total count of ones even.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Frame FSM: IDLE = no frame open, ACTIVE = frame open.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Reduction parity of a word, inverted when odd parity is selected.
  function automatic logic word_parity(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/pbgen_word.sv
// Combinational DATA_W-wide word parity generator with even/odd mode select.
// DATA_W must not exceed pbgen_pkg::MAX_DATA_W.
module pbgen_word
  import pbgen_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              mode_i,
  output logic              par_c_o
);

  // Zero-extend to the helper width and apply the mode adjust.
  always_comb begin
    par_c_o = word_parity(MAX_DATA_W'(data_i), mode_i);
  end

endmodule

// File: rtl/pbgen_frame.sv
// Registered per-word parity generator/checker with frame-level parity
// accumulation, word counting and forced frame close at MAX_WORDS.
module pbgen_frame
  import pbgen_pkg::*;
#(
  parameter  int unsigned DATA_W    = 4,
  parameter  int unsigned MAX_WORDS = 16,
  parameter  int unsigned ERR_CNT_W = 8,
  localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_last,
  input  logic                 odd_mode,
  input  logic                 chk_en,
  input  logic                 chk_bit,
  output logic                 out_valid,
  output logic                 out_par,
  output logic                 frame_done,
  output logic                 frame_par,
  output logic                 frame_trunc,
  output logic [CNT_W-1:0]     word_cnt,
  output logic                 par_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_WORDS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 acc_q, acc_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_par_q, out_par_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_par_q, frame_par_d;
  logic                 frame_trunc_q, frame_trunc_d;
  logic                 par_err_q, par_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 opening_c;
  logic                 eff_mode_c;
  logic                 word_par_c;
  logic                 raw_par_c;
  logic                 acc_next_c;
  logic [CNT_W-1:0]     cnt_next_c;
  logic                 close_c;
  logic                 err_hit_c;

  // A valid word seen while no frame is open starts a new frame and supplies
  // the parity mode for itself; later words use the mode latched at open.
  always_comb begin
    opening_c  = in_valid && (state_q == ST_IDLE);
    eff_mode_c = opening_c ? odd_mode : mode_q;
  end

  // Single parity generator shared by the output path and the checker.
  pbgen_word #(
    .DATA_W (DATA_W)
  ) u_word (
    .data_i  (in_data),
    .mode_i  (eff_mode_c),
    .par_c_o (word_par_c)
  );

  // Frame bookkeeping: unadjusted word parity feeds the accumulator, and the
  // frame closes on in_last or when the incoming word reaches MAX_WORDS.
  always_comb begin
    raw_par_c  = word_par_c ^ eff_mode_c;
    acc_next_c = (opening_c ? 1'b0 : acc_q) ^ raw_par_c;
    cnt_next_c = opening_c ? CNT_ONE : (word_cnt_q + CNT_ONE);
    close_c    = in_valid && (in_last || (cnt_next_c == CNT_MAX));
    err_hit_c  = in_valid && chk_en && (chk_bit != word_par_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    acc_d         = acc_q;
    word_cnt_d    = word_cnt_q;
    out_valid_d   = in_valid;
    out_par_d     = out_par_q;
    frame_done_d  = 1'b0;
    frame_par_d   = frame_par_q;
    frame_trunc_d = 1'b0;
    par_err_d     = err_hit_c;
    err_cnt_d     = err_cnt_q;

    if (in_valid) begin
      out_par_d  = word_par_c;
      acc_d      = acc_next_c;
      word_cnt_d = cnt_next_c;
      if (opening_c) begin
        mode_d = odd_mode;
      end
      if (close_c) begin
        state_d       = ST_IDLE;
        frame_done_d  = 1'b1;
        frame_par_d   = acc_next_c ^ eff_mode_c;
        frame_trunc_d = !in_last;
      end else begin
        state_d = ST_ACTIVE;
      end
    end

    if (err_hit_c && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers; reset aborts any open frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= PAR_EVEN;
      acc_q         <= 1'b0;
      word_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      out_par_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_par_q   <= 1'b0;
      frame_trunc_q <= 1'b0;
      par_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      acc_q         <= acc_d;
      word_cnt_q    <= word_cnt_d;
      out_valid_q   <= out_valid_d;
      out_par_q     <= out_par_d;
      frame_done_q  <= frame_done_d;
      frame_par_q   <= frame_par_d;
      frame_trunc_q <= frame_trunc_d;
      par_err_q     <= par_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_par     = out_par_q;
  assign frame_done  = frame_done_q;
  assign frame_par   = frame_par_q;
  assign frame_trunc = frame_trunc_q;
  assign word_cnt    = word_cnt_q;
  assign par_err     = par_err_q;
  assign err_cnt     = err_cnt_q;

endmodule
